// File: rtl/vga_timing_gen_pkg.sv
// Raster timing constants and types for the 1024x768@60 video path.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: none; raster timing is free-running.
//
// Contents: default 1024x768@60 geometry, derived totals and sync windows,
// the vga_timing_t bundle carried through the delay line, and its reset value.
package vga_timing_pkg;

  // Default 1024x768@60 geometry (65 MHz pixel clock).
  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_BP     = 160;
  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 29;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1344
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 806

  // Sync windows are half-open: [START, END).
  localparam int unsigned HS_START = H_ACTIVE + H_FP;                  // 1048
  localparam int unsigned HS_END   = HS_START + H_SYNC;                // 1184
  localparam int unsigned VS_START = V_ACTIVE + V_FP;                  // 771
  localparam int unsigned VS_END   = VS_START + V_SYNC;                // 777

  localparam int unsigned HCNT_W   = 11;
  localparam int unsigned VCNT_W   = 10;
  localparam int unsigned FRAME_W  = 16;

  // Legal range of the delay-line depth.
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 8;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              blank;
  } vga_timing_t;

  // Delay stages come out of reset showing "blanked, no sync" so the
  // downstream colour gate stays dark until real timing arrives.
  localparam vga_timing_t TIMING_RST = '{
    hcount: '0,
    vcount: '0,
    hsync:  1'b0,
    vsync:  1'b0,
    blank:  1'b1
  };

  // Half-open window test done at a common 16-bit unsigned width so no
  // operand is ever truncated.
  function automatic logic in_window(input logic [15:0] pos,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of raster timing outputs (live and delayed copies, frame events).
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept timing every cycle.
//
// master: driven by vga_timing_gen.  slave: the sprite/colour consumer.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [HCNT_W-1:0]  hcount_out;
  logic [VCNT_W-1:0]  vcount_out;
  logic               hsync_out;
  logic               vsync_out;
  logic               blank_out;
  logic [HCNT_W-1:0]  hcount_d_out;
  logic [VCNT_W-1:0]  vcount_d_out;
  logic               hsync_d_out;
  logic               vsync_d_out;
  logic               blank_d_out;
  logic               new_frame_out;
  logic [FRAME_W-1:0] frame_count_out;

  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
    output hcount_d_out, vcount_d_out, hsync_d_out, vsync_d_out, blank_d_out,
    output new_frame_out, frame_count_out
  );

  modport slave (
    input hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
    input hcount_d_out, vcount_d_out, hsync_d_out, vsync_d_out, blank_d_out,
    input new_frame_out, frame_count_out
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-depth shift register with a synchronous reset value per stage.
// Latency: DEPTH cycles from data_in to data_out.
// Backpressure: none; shifts every cycle.
//
// Ports: pixel_clk_in (clock), rst_n_in (sync active-low reset),
//        data_in (WIDTH), data_out (WIDTH, data_in delayed DEPTH cycles).
module delay_line #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= data_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing source: h/v counters, sync/blank decode, frame events.
// Latency: live outputs registered (flags aligned with counts); *_d_out copies lag by LATENCY.
// Backpressure: none; timing advances every pixel clock regardless of the consumer.
//
// Ports: pixel_clk_in (65 MHz), rst_n_in (sync active-low reset),
//        vid (vga_timing_gen_if.master): live and delayed timing, new_frame, frame_count.
// LATENCY must stay within LATENCY_MIN..LATENCY_MAX of the package.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned LATENCY  = 2
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  vga_timing_gen_if.master vid
);

  localparam int unsigned HW    = vga_timing_pkg::HCNT_W;
  localparam int unsigned VW    = vga_timing_pkg::VCNT_W;
  localparam int unsigned FW    = vga_timing_pkg::FRAME_W;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  // Decode thresholds at 16 bits; counters are zero-extended to match.
  localparam logic [15:0] HA_LIM = 16'(H_ACTIVE);
  localparam logic [15:0] VA_LIM = 16'(V_ACTIVE);
  localparam logic [15:0] HS_LO  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_HI  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_LO  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_HI  = 16'(V_ACTIVE + V_FP + V_SYNC);

  vga_timing_pkg::vga_timing_t timing_q;
  vga_timing_pkg::vga_timing_t timing_nxt;
  vga_timing_pkg::vga_timing_t timing_d;

  logic [HW-1:0] hcount_nxt;
  logic [VW-1:0] vcount_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_wrap;
  logic          new_frame_q;
  logic [FW-1:0] frame_cnt_q;

  // Next-state counters, with sync/blank decoded from the *next* values so
  // the registered flags land in the same cycle as the count they describe.
  always_comb begin
    h_wrap     = (timing_q.hcount == H_LAST);
    v_wrap     = (timing_q.vcount == V_LAST);
    frame_wrap = h_wrap && v_wrap;

    hcount_nxt = h_wrap ? '0 : timing_q.hcount + HW'(1);
    vcount_nxt = timing_q.vcount;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? '0 : timing_q.vcount + VW'(1);
    end

    timing_nxt        = '0;
    timing_nxt.hcount = hcount_nxt;
    timing_nxt.vcount = vcount_nxt;
    timing_nxt.hsync  = vga_timing_pkg::in_window(16'(hcount_nxt), HS_LO, HS_HI);
    // Vertical sync follows line boundaries only; independent of hsync.
    timing_nxt.vsync  = vga_timing_pkg::in_window(16'(vcount_nxt), VS_LO, VS_HI);
    timing_nxt.blank  = (16'(hcount_nxt) >= HA_LIM) || (16'(vcount_nxt) >= VA_LIM);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      timing_q    <= '0;
      new_frame_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      timing_q    <= timing_nxt;
      // Pulse lands with the (0,0) count produced by the double wrap.
      new_frame_q <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end

  // Delayed copy of the registered timing, so the consumer can line sync and
  // blank up with its memory read latency.
  delay_line #(
    .WIDTH     ($bits(vga_timing_pkg::vga_timing_t)),
    .DEPTH     (LATENCY),
    .RESET_VAL (vga_timing_pkg::TIMING_RST)
  ) u_delay (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .data_in      (timing_q),
    .data_out     (timing_d)
  );

  assign vid.hcount_out      = timing_q.hcount;
  assign vid.vcount_out      = timing_q.vcount;
  assign vid.hsync_out       = timing_q.hsync;
  assign vid.vsync_out       = timing_q.vsync;
  assign vid.blank_out       = timing_q.blank;
  assign vid.hcount_d_out    = timing_d.hcount;
  assign vid.vcount_d_out    = timing_d.vcount;
  assign vid.hsync_d_out     = timing_d.hsync;
  assign vid.vsync_d_out     = timing_d.vsync;
  assign vid.blank_d_out     = timing_d.blank;
  assign vid.new_frame_out   = new_frame_q;
  assign vid.frame_count_out = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-geometry instance (LATENCY=2) and two
// small-geometry instances (LATENCY=1 and 8) sharing clock and reset, each
// compared every cycle against a raster model built from cycles-since-reset.
module tb_vga_timing_gen;

  localparam int NI = 3;

  // Instance 0: 1024x768@60.  Instances 1,2: small raster (25 x 13) so whole
  // frames fit in a short run.
  localparam int unsigned HA_T  [NI] = '{1024, 16, 16};
  localparam int unsigned HFP_T [NI] = '{24,   2,  2};
  localparam int unsigned HSW_T [NI] = '{136,  4,  4};
  localparam int unsigned HBP_T [NI] = '{160,  3,  3};
  localparam int unsigned VA_T  [NI] = '{768,  8,  8};
  localparam int unsigned VFP_T [NI] = '{3,    1,  1};
  localparam int unsigned VSW_T [NI] = '{6,    2,  2};
  localparam int unsigned VBP_T [NI] = '{29,   2,  2};
  localparam int unsigned LAT_T [NI] = '{2,    1,  8};

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
  } tim_t;

  typedef struct packed {
    tim_t        s;
    tim_t        d;
    logic        nf;
    logic [15:0] fc;
  } obs_t;

  localparam tim_t RST_D = {11'd0, 10'd0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_gen_if vid_d ();
  vga_timing_gen_if vid_1 ();
  vga_timing_gen_if vid_8 ();

  vga_timing_gen #(.LATENCY(2)) u_dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vid          (vid_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .LATENCY(1)
  ) u_s1 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vid          (vid_1)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .LATENCY(8)
  ) u_s8 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .vid          (vid_8)
  );

  // ---------------- reference model ----------------
  obs_t        sbq     [NI][$];
  tim_t        hist_m  [NI][$];
  int unsigned n_m     [NI];
  int unsigned since_m [NI];
  logic [15:0] fc_m    [NI];

  int total = 0;
  int bad   = 0;

  function automatic int unsigned htot(input int i);
    return HA_T[i] + HFP_T[i] + HSW_T[i] + HBP_T[i];
  endfunction

  function automatic int unsigned vtot(input int i);
    return VA_T[i] + VFP_T[i] + VSW_T[i] + VBP_T[i];
  endfunction

  // Raster position and flags n pixel clocks after reset.
  function automatic tim_t raster(input int i, input int unsigned n);
    int unsigned h;
    int unsigned v;
    tim_t        t;
    h    = n % htot(i);
    v    = (n / htot(i)) % vtot(i);
    t.h  = 11'(h);
    t.v  = 10'(v);
    t.hs = (h >= HA_T[i] + HFP_T[i]) && (h < HA_T[i] + HFP_T[i] + HSW_T[i]);
    t.vs = (v >= VA_T[i] + VFP_T[i]) && (v < VA_T[i] + VFP_T[i] + VSW_T[i]);
    t.bl = (h >= HA_T[i]) || (v >= VA_T[i]);
    return t;
  endfunction

  // Expected outputs after the coming clock edge, given rst_n at that edge.
  task automatic model_step(input int i, input logic r);
    tim_t src;
    obs_t e;
    e = '0;
    if (!r) begin
      n_m[i]     = 0;
      since_m[i] = 0;
      fc_m[i]    = 16'h0000;
      hist_m[i].delete();
      src        = '0;
    end else begin
      n_m[i]++;
      since_m[i]++;
      if ((n_m[i] % (htot(i) * vtot(i))) == 0) begin
        e.nf    = 1'b1;
        fc_m[i] = fc_m[i] + 16'h0001;
      end
      src = raster(i, n_m[i]);
    end
    hist_m[i].push_back(src);
    if (hist_m[i].size() > int'(LAT_T[i]) + 1) void'(hist_m[i].pop_front());
    e.s  = src;
    e.fc = fc_m[i];
    e.d  = (since_m[i] >= LAT_T[i]) ? hist_m[i][0] : RST_D;
    sbq[i].push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r);
    rst_n = r;
    for (int i = 0; i < NI; i++) model_step(i, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int i, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, got, want);
    end
  endtask

  initial begin
    obs_t act [NI];
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      act[0] = {vid_d.hcount_out, vid_d.vcount_out, vid_d.hsync_out, vid_d.vsync_out,
                vid_d.blank_out, vid_d.hcount_d_out, vid_d.vcount_d_out, vid_d.hsync_d_out,
                vid_d.vsync_d_out, vid_d.blank_d_out, vid_d.new_frame_out, vid_d.frame_count_out};
      act[1] = {vid_1.hcount_out, vid_1.vcount_out, vid_1.hsync_out, vid_1.vsync_out,
                vid_1.blank_out, vid_1.hcount_d_out, vid_1.vcount_d_out, vid_1.hsync_d_out,
                vid_1.vsync_d_out, vid_1.blank_d_out, vid_1.new_frame_out, vid_1.frame_count_out};
      act[2] = {vid_8.hcount_out, vid_8.vcount_out, vid_8.hsync_out, vid_8.vsync_out,
                vid_8.blank_out, vid_8.hcount_d_out, vid_8.vcount_d_out, vid_8.hsync_d_out,
                vid_8.vsync_d_out, vid_8.blank_d_out, vid_8.new_frame_out, vid_8.frame_count_out};
      for (int i = 0; i < NI; i++) begin
        if (sbq[i].size() > 0) begin
          e = sbq[i].pop_front();
          chk("counts", i, 64'({act[i].s.h, act[i].s.v}), 64'({e.s.h, e.s.v}));
          chk("flags",  i, 64'({act[i].s.hs, act[i].s.vs, act[i].s.bl}),
                           64'({e.s.hs, e.s.vs, e.s.bl}));
          chk("delayed", i, 64'(act[i].d), 64'(e.d));
          chk("frame",  i, 64'({act[i].nf, act[i].fc}), 64'({e.nf, e.fc}));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_n = 1'b0;

    // Power-on reset, then long free run: two default lines and many small frames.
    repeat (5) cycle(1'b0);
    repeat (3000) cycle(1'b1);

    // Preload the frame counter of the LATENCY=8 instance shortly before a wrap.
    k = 0;
    while (((n_m[2] % (htot(2) * vtot(2))) != (htot(2) * vtot(2) - 6)) && (k < 400)) begin
      cycle(1'b1);
      k++;
    end
    fc_m[2] = 16'hFFFF;
    force u_s8.frame_cnt_q = 16'hFFFF;
    cycle(1'b1);
    release u_s8.frame_cnt_q;
    repeat (400) cycle(1'b1);

    // One-cycle reset while the default raster shows h=600, mid-frame.
    k = 0;
    while (((n_m[0] % htot(0)) != 600) && (k < 2000)) begin
      cycle(1'b1);
      k++;
    end
    cycle(1'b0);
    repeat (2000) cycle(1'b1);

    // Random reset pulses at random points.
    repeat (8) begin
      repeat ($urandom_range(700, 50)) cycle(1'b1);
      repeat ($urandom_range(3, 1)) cycle(1'b0);
    end
    repeat (700) cycle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
